pc_next_unit: RTL and testbench
===============================

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter width in bits.
REQ-002 SHALL have parameter PC_INC, default 1, sequential increment.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded by reset.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC.
- redirectValid  in  1  pipeline redirect request.
- redirectPc  in  PC_W  redirect target.
- branchTaken  in  1  branch condition met.
- branchTarget  in  PC_W  branch target.
- jump  in  1  unconditional jump.
- jumpTarget  in  PC_W  jump/call target.
- call  in  1  call request: jump plus push of return address.
- ret  in  1  return: pop return address.
- pc  out  PC_W  registered current PC.
- pcPlus  out  PC_W  pc+PC_INC, combinational.
- redirected  out  1  registered pulse: current pc came from a non-sequential source.
- rasEmpty  out  1  stack empty.
- rasUnderflow  out  1  registered pulse: ret issued while empty.

Function
REQ-006 SHALL compute next PC with fixed priority: redirectValid > stall > branchTaken > jump/call > ret > sequential.
REQ-007 SHALL load redirectPc when redirectValid=1, even while stall=1.
REQ-008 SHALL hold pc and RAS unchanged when stall=1 and redirectValid=0; redirected=0 that cycle.
REQ-009 SHALL load branchTarget on branchTaken; jumpTarget on jump or call; RAS top on ret with non-empty stack; otherwise pcPlus.
REQ-010 SHALL update pc one cycle after the request (latency 1); pcPlus SHALL track pc combinationally.
REQ-011 SHALL perform all PC arithmetic modulo 2^PC_W (wrap, no carry out).
REQ-012 SHALL assert redirected for exactly the cycle after any redirect, branch, jump, call or successful ret load.
REQ-013 SHALL push pcPlus on an accepted call; a push when full SHALL overwrite the oldest entry (circular), count saturating at RAS_DEPTH.
REQ-014 SHALL treat ret on an empty stack as sequential, pulse rasUnderflow one cycle, leave count at 0.
REQ-015 SHALL, with call and ret both asserted, honour call only; ret ignored.
REQ-016 SHALL perform no push/pop when a higher-priority source (redirect, stall, branch) wins the cycle.
REQ-017 SHALL clear the RAS on an accepted redirectValid.

Reset
REQ-018 SHALL on rst_n=0 asynchronously set pc=RESET_PC, redirected=0, rasUnderflow=0, RAS count=0 (rasEmpty=1).
REQ-019 SHALL discard any in-flight request on reset assertion mid-operation; first post-reset edge uses normal priority.

Configuration
REQ-020 SHALL compile the RAS in only when PC_NEXT_RAS_EN is defined.
REQ-021 SHALL, without PC_NEXT_RAS_EN, treat call as jump, ignore ret (sequential), tie rasEmpty=1, rasUnderflow=0, and instantiate no stack storage.

Structure
REQ-022 SHALL place next-PC source select encoding and default parameter constants in shared package pc_pkg.
REQ-023 SHALL implement the stack as sub-module pc_ras (push, pop, top, empty, full, count).

Verification (PC_W=8, PC_INC=1, RESET_PC=0, RAS_DEPTH=4, macro defined)
REQ-024 SHALL check: release reset, 3 idle cycles -> pc 0,1,2,3; redirected=0.
REQ-025 SHALL check: pc=0xFE, idle 2 cycles -> pc 0xFF then 0x00 (wrap).
REQ-026 SHALL check: pc=0x10, stall=1 and branchTaken=1 target 0x40 -> pc stays 0x10; add redirectValid pc 0x80 -> pc 0x80, redirected=1 next cycle.
REQ-027 SHALL check: pc=0x20, call target 0x50 -> pc 0x50; later ret -> pc 0x21, redirected=1.
REQ-028 SHALL check: 5 nested calls from pc 0x01,0x11,0x21,0x31,0x41 then 5 rets -> returns 0x42,0x32,0x22,0x12, then sequential with rasUnderflow=1.
REQ-029 SHALL check: assert rst_n=0 mid-call sequence -> pc=0 immediately, rasEmpty=1; with macro undefined, ret at pc 0x05 -> pc 0x06.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants and next-PC source selection for pc_next_unit.
package pc_pkg;

  localparam int unsigned PC_W_DEF      = 8;
  localparam int unsigned PC_INC_DEF    = 1;
  localparam int unsigned RESET_PC_DEF  = 0;
  localparam int unsigned RAS_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    SRC_SEQ      = 3'd0,
    SRC_HOLD     = 3'd1,
    SRC_REDIRECT = 3'd2,
    SRC_BRANCH   = 3'd3,
    SRC_JUMP     = 3'd4,
    SRC_RET      = 3'd5
  } pc_src_e;

  // Fixed priority: redirect > stall > branch > jump/call > ret(non-empty) > sequential.
  function automatic pc_src_e pc_src_sel(input logic redirect_v,
                                         input logic stall_v,
                                         input logic branch_v,
                                         input logic jump_v,
                                         input logic ret_v);
    pc_src_e src;
    if (redirect_v)    src = SRC_REDIRECT;
    else if (stall_v)  src = SRC_HOLD;
    else if (branch_v) src = SRC_BRANCH;
    else if (jump_v)   src = SRC_JUMP;
    else if (ret_v)    src = SRC_RET;
    else               src = SRC_SEQ;
    return src;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned W     = PC_W_DEF,
  parameter int unsigned DEPTH = RAS_DEPTH_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     top_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign top_o   = mem_q[sp_q - PTR_W'(1)];

  // sp_q points at the next free slot; clear beats push beats pop.
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    wr_en = 1'b0;
    if (clear_i) begin
      sp_d  = '0;
      cnt_d = '0;
    end else if (push_i) begin
      wr_en = 1'b1;
      sp_d  = sp_q + PTR_W'(1);
      if (!full_o) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_d  = sp_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      if (wr_en) mem_q[sp_q] <= data_i;
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC selection with prioritized redirect/stall/branch/jump/call/ret sources.
// Return-address stack is built only when PC_NEXT_RAS_EN is defined.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned PC_INC    = PC_INC_DEF,
  parameter int unsigned RESET_PC  = RESET_PC_DEF,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirectValid,
  input  logic [PC_W-1:0] redirectPc,
  input  logic            branchTaken,
  input  logic [PC_W-1:0] branchTarget,
  input  logic            jump,
  input  logic [PC_W-1:0] jumpTarget,
  input  logic            call,
  input  logic            ret,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pcPlus,
  output logic            redirected,
  output logic            rasEmpty,
  output logic            rasUnderflow
);

  logic [PC_W-1:0] pc_q, pc_d, pc_plus;
  logic            redir_q, redir_d;
  logic            unf_q, unf_d;
  logic            ret_eff;
  logic            ras_push, ras_pop, ras_clear, ras_empty;
  logic [PC_W-1:0] ras_top;
  pc_src_e         src;

  assign pc_plus    = pc_q + PC_W'(PC_INC);
  assign pc         = pc_q;
  assign pcPlus     = pc_plus;
  assign redirected = redir_q;

`ifdef PC_NEXT_RAS_EN
  logic                      ras_full_unused;
  logic [$clog2(RAS_DEPTH):0] ras_count_unused;

  assign ret_eff      = ret;
  assign rasEmpty     = ras_empty;
  assign rasUnderflow = unf_q;

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (ras_clear),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc_plus),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full_unused),
    .count_o (ras_count_unused)
  );
`else
  logic unused_ras;

  // Without the stack, ret falls through to sequential and call acts as a plain jump.
  assign ret_eff      = 1'b0;
  assign ras_empty    = 1'b1;
  assign ras_top      = '0;
  assign rasEmpty     = 1'b1;
  assign rasUnderflow = 1'b0;
  assign unused_ras   = ^{ret, ras_push, ras_pop, ras_clear, unf_q};
`endif

  always_comb begin
    pc_d      = pc_q;
    redir_d   = 1'b0;
    unf_d     = 1'b0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = 1'b0;
    src       = pc_src_sel(redirectValid, stall, branchTaken, jump | call,
                           ret_eff & ~ras_empty);
    unique case (src)
      SRC_REDIRECT: begin
        pc_d      = redirectPc;
        redir_d   = 1'b1;
        ras_clear = 1'b1;
      end
      SRC_HOLD: pc_d = pc_q;
      SRC_BRANCH: begin
        pc_d    = branchTarget;
        redir_d = 1'b1;
      end
      SRC_JUMP: begin
        pc_d     = jumpTarget;
        redir_d  = 1'b1;
        ras_push = call;
      end
      SRC_RET: begin
        pc_d    = ras_top;
        redir_d = 1'b1;
        ras_pop = 1'b1;
      end
      default: begin
        // A ret that reaches here found the stack empty.
        pc_d  = pc_plus;
        unf_d = ret_eff & ras_empty;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= PC_W'(RESET_PC);
      redir_q <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      redir_q <= redir_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit against a queue-based behavioural model.
module tb_pc_next_unit;

`ifdef PC_NEXT_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0, redirectValid = 1'b0, branchTaken = 1'b0;
  logic       jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic [7:0] redirectPc = '0, branchTarget = '0, jumpTarget = '0;
  logic [7:0] pc, pcPlus;
  logic       redirected, rasEmpty, rasUnderflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_pc;
  logic       m_redir, m_unf;
  logic [7:0] m_ras [$];

  pc_next_unit #(
    .PC_W(8), .PC_INC(1), .RESET_PC(0), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirectValid(redirectValid), .redirectPc(redirectPc),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jump(jump), .jumpTarget(jumpTarget), .call(call), .ret(ret),
    .pc(pc), .pcPlus(pcPlus), .redirected(redirected),
    .rasEmpty(rasEmpty), .rasUnderflow(rasUnderflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 8'h00; m_redir = 1'b0; m_unf = 1'b0;
    m_ras.delete();
  endtask

  // Next state from the priority rules, using the inputs that will be sampled.
  task automatic model_step();
    logic [7:0] nxt;
    nxt = m_pc + 8'd1;
    m_redir = 1'b0; m_unf = 1'b0;
    if (redirectValid) begin
      m_pc = redirectPc; m_redir = 1'b1; m_ras.delete();
    end else if (stall) begin
      m_pc = m_pc;
    end else if (branchTaken) begin
      m_pc = branchTarget; m_redir = 1'b1;
    end else if (jump || call) begin
      if (call && RAS_EN) begin
        m_ras.push_back(nxt);
        if (m_ras.size() > DEPTH) m_ras.delete(0);
      end
      m_pc = jumpTarget; m_redir = 1'b1;
    end else if (ret && RAS_EN) begin
      if (m_ras.size() > 0) begin
        m_pc = m_ras.pop_back(); m_redir = 1'b1;
      end else begin
        m_pc = nxt; m_unf = 1'b1;
      end
    end else begin
      m_pc = nxt;
    end
  endtask

  task automatic idle();
    stall = 0; redirectValid = 0; branchTaken = 0; jump = 0; call = 0; ret = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [7:0] addr);
    idle(); redirectValid = 1'b1; redirectPc = addr; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); rst_n = 1'b0; model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", pc); end
    checks++; if (redirected !== 1'b0 || rasUnderflow !== 1'b0 || rasEmpty !== 1'b1) begin
      errors++; $display("FAIL reset_flags got redir=%b unf=%b empty=%b exp 0 0 1", redirected, rasUnderflow, rasEmpty);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL release_pc got=%h exp=00", pc); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc !== 8'(i) || redirected !== 1'b0) begin
        errors++; $display("FAIL idle_seq%0d got pc=%h redir=%b exp pc=%h redir=0", i, pc, redirected, 8'(i));
      end
    end
  endtask

  task automatic test_wrap();
    go_to(8'hFE);
    checks++; if (pc !== 8'hFE || redirected !== 1'b1) begin errors++; $display("FAIL wrap_load got pc=%h redir=%b exp FE 1", pc, redirected); end
    tick();
    checks++; if (pc !== 8'hFF || redirected !== 1'b0) begin errors++; $display("FAIL wrap_ff got pc=%h redir=%b exp FF 0", pc, redirected); end
    tick();
    checks++; if (pc !== 8'h00 || pcPlus !== 8'h01) begin errors++; $display("FAIL wrap_00 got pc=%h plus=%h exp 00 01", pc, pcPlus); end
  endtask

  task automatic test_stall_redirect();
    go_to(8'h10);
    stall = 1; branchTaken = 1; branchTarget = 8'h40; call = 1; jumpTarget = 8'h66;
    tick();
    checks++; if (pc !== 8'h10 || redirected !== 1'b0) begin errors++; $display("FAIL stall_hold got pc=%h redir=%b exp 10 0", pc, redirected); end
    checks++; if (rasEmpty !== 1'b1) begin errors++; $display("FAIL stall_nopush got empty=%b exp 1", rasEmpty); end
    redirectValid = 1; redirectPc = 8'h80;
    tick(); idle();
    checks++; if (pc !== 8'h80 || redirected !== 1'b1) begin errors++; $display("FAIL stall_redirect got pc=%h redir=%b exp 80 1", pc, redirected); end
  endtask

  task automatic test_call_ret();
    logic [7:0] exp_pc;
    go_to(8'h20);
    call = 1; jumpTarget = 8'h50; tick(); idle();
    checks++; if (pc !== 8'h50 || redirected !== 1'b1) begin errors++; $display("FAIL call_pc got pc=%h redir=%b exp 50 1", pc, redirected); end
    checks++; if (rasEmpty !== !RAS_EN) begin errors++; $display("FAIL call_push got empty=%b exp %b", rasEmpty, !RAS_EN); end
    tick(); tick();
    ret = 1; tick(); idle();
    exp_pc = RAS_EN ? 8'h21 : 8'h53;
    checks++; if (pc !== exp_pc || redirected !== RAS_EN) begin errors++; $display("FAIL ret_pc got pc=%h redir=%b exp %h %b", pc, redirected, exp_pc, RAS_EN); end
  endtask

  task automatic test_nested();
    logic [7:0] exp_pc;
    go_to(8'h01);
    for (int i = 0; i < 5; i++) begin
      call = 1; jumpTarget = (i < 4) ? 8'(8'h11 + 8'h10 * i) : 8'h99;
      tick(); idle();
      checks++; if (pc !== jumpTarget) begin errors++; $display("FAIL nest_call%0d got pc=%h exp %h", i, pc, jumpTarget); end
    end
    for (int i = 0; i < 4; i++) begin
      ret = 1; tick(); idle();
      exp_pc = RAS_EN ? 8'(8'h42 - 8'h10 * i) : 8'(8'h9A + i);
      checks++; if (pc !== exp_pc || redirected !== RAS_EN) begin
        errors++; $display("FAIL nest_ret%0d got pc=%h redir=%b exp %h %b", i, pc, redirected, exp_pc, RAS_EN);
      end
    end
    ret = 1; tick(); idle();
    exp_pc = RAS_EN ? 8'h13 : 8'h9E;
    checks++; if (pc !== exp_pc || redirected !== 1'b0 || rasUnderflow !== RAS_EN || rasEmpty !== 1'b1) begin
      errors++; $display("FAIL nest_underflow got pc=%h redir=%b unf=%b empty=%b exp %h 0 %b 1", pc, redirected, rasUnderflow, rasEmpty, exp_pc, RAS_EN);
    end
    tick();
    checks++; if (rasUnderflow !== 1'b0) begin errors++; $display("FAIL unf_pulse got unf=%b exp 0", rasUnderflow); end
  endtask

  task automatic test_reset_mid();
    go_to(8'h30);
    call = 1; jumpTarget = 8'h60; tick();
    jumpTarget = 8'h70;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (pc !== 8'h00 || rasEmpty !== 1'b1 || redirected !== 1'b0) begin
      errors++; $display("FAIL reset_mid got pc=%h empty=%b redir=%b exp 00 1 0", pc, rasEmpty, redirected);
    end
    @(posedge clk); #1;
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_held got pc=%h exp 00", pc); end
    @(negedge clk); rst_n = 1'b1;
    tick(); idle();
    checks++; if (pc !== 8'h70 || redirected !== 1'b1 || rasEmpty !== !RAS_EN) begin
      errors++; $display("FAIL post_reset_call got pc=%h redir=%b empty=%b exp 70 1 %b", pc, redirected, rasEmpty, !RAS_EN);
    end
  endtask

  task automatic test_ret_empty();
    go_to(8'h05);
    ret = 1; tick(); idle();
    checks++; if (pc !== 8'h06 || redirected !== 1'b0 || rasUnderflow !== RAS_EN) begin
      errors++; $display("FAIL ret_empty got pc=%h redir=%b unf=%b exp 06 0 %b", pc, redirected, rasUnderflow, RAS_EN);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_pc;
    go_to(8'h40);
    call = 1; ret = 1; jumpTarget = 8'h10; tick(); idle();
    checks++; if (pc !== 8'h10 || rasEmpty !== !RAS_EN) begin errors++; $display("FAIL call_and_ret got pc=%h empty=%b exp 10 %b", pc, rasEmpty, !RAS_EN); end
    ret = 1; tick(); idle();
    exp_pc = RAS_EN ? 8'h41 : 8'h11;
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL b2b_ret got pc=%h exp %h", pc, exp_pc); end
    branchTaken = 1; branchTarget = 8'h77; call = 1; jumpTarget = 8'h33; tick(); idle();
    checks++; if (pc !== 8'h77 || rasEmpty !== 1'b1) begin errors++; $display("FAIL branch_over_call got pc=%h empty=%b exp 77 1", pc, rasEmpty); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      redirectValid = ($urandom_range(15) == 0);
      stall         = ($urandom_range(5) == 0);
      branchTaken   = ($urandom_range(7) == 0);
      jump          = ($urandom_range(9) == 0);
      call          = ($urandom_range(4) == 0);
      ret           = ($urandom_range(2) == 0);
      redirectPc    = 8'($urandom);
      branchTarget  = 8'($urandom);
      jumpTarget    = 8'($urandom);
      tick();
      checks++; if (pc !== m_pc || pcPlus !== 8'(m_pc + 8'd1)) begin
        errors++; $display("FAIL rand_pc[%0d] got pc=%h plus=%h exp %h %h", n, pc, pcPlus, m_pc, 8'(m_pc + 8'd1));
      end
      checks++; if (redirected !== m_redir || rasUnderflow !== m_unf || rasEmpty !== (m_ras.size() == 0)) begin
        errors++; $display("FAIL rand_flags[%0d] got redir=%b unf=%b empty=%b exp %b %b %b", n, redirected, rasUnderflow, rasEmpty, m_redir, m_unf, m_ras.size() == 0);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_stall_redirect();
    test_call_ret();
    test_nested();
    test_reset_mid();
    test_ret_empty();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
